// File: rtl/sector_sequencer_pkg.sv
// Shared definitions for the LED sector display: main FSM state encodings
// and the default timing and geometry parameters.
package sector_sequencer_pkg;

    // The button handler compares main_state against ST_DONE, so these values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int DEF_DWELL_CYCLES = 25000000;
    localparam int DEF_N_SECTORS    = 8;
    localparam int DEF_N_GROUPS     = 4;

    // Counter width for a modulo-n count; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sector_sequencer_if.sv
// Control and status bundle between the button handler and the sector sequencer.
interface sector_sequencer_if #(
    parameter int N_SECTORS = 8,
    parameter int SECTOR_W  = 3,
    parameter int GROUP_W   = 2
);
    import sector_sequencer_pkg::*;

    logic                 start_pulse;
    logic                 change_sector_group;
    logic                 abort;
    state_t               main_state;
    logic [GROUP_W-1:0]   sector_group;
    logic [SECTOR_W-1:0]  sector_idx;
    logic [N_SECTORS-1:0] led_mask;
    logic                 busy;
    logic                 done_pulse;

    modport master (
        output start_pulse, change_sector_group, abort,
        input  main_state, sector_group, sector_idx, led_mask, busy, done_pulse
    );

    modport slave (
        input  start_pulse, change_sector_group, abort,
        output main_state, sector_group, sector_idx, led_mask, busy, done_pulse
    );

endinterface

// File: rtl/sector_sequencer_dwell_timer.sv
// Dwell counter for one sector step: counts enabled cycles and raises tick on
// the last cycle of each DWELL_CYCLES-long step, wrapping to zero on its own.
module sector_sequencer_dwell_timer #(
    parameter int DWELL_CYCLES = sector_sequencer_pkg::DEF_DWELL_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    import sector_sequencer_pkg::*;

    localparam int            CW   = cnt_width(DWELL_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

    logic [CW-1:0] dwell_cnt;

    assign tick = enable && (dwell_cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell_cnt <= '0;
        end else if (clear) begin
            dwell_cnt <= '0;
        end else if (enable) begin
            dwell_cnt <= tick ? '0 : dwell_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sector_sequencer.sv
// Main control FSM for the LED sector display: fills the sectors of the active
// group one dwell step at a time, then waits in DONE for a restart or group change.
module sector_sequencer #(
    parameter int DWELL_CYCLES = sector_sequencer_pkg::DEF_DWELL_CYCLES,
    parameter int N_SECTORS    = sector_sequencer_pkg::DEF_N_SECTORS,
    parameter int N_GROUPS     = sector_sequencer_pkg::DEF_N_GROUPS,
    parameter int SECTOR_W     = 3,
    parameter int GROUP_W      = 2
) (
    input  logic               clk,
    input  logic               reset,
    sector_sequencer_if.slave  bus
);
    import sector_sequencer_pkg::*;

    localparam logic [SECTOR_W-1:0]  LAST_SECTOR = SECTOR_W'(N_SECTORS - 1);
    localparam logic [GROUP_W-1:0]   LAST_GROUP  = GROUP_W'(N_GROUPS - 1);
    localparam logic [N_SECTORS-1:0] FIRST_MASK  = N_SECTORS'(1);

    state_t               state;
    logic [SECTOR_W-1:0]  sector_idx;
    logic [GROUP_W-1:0]   sector_group;
    logic [N_SECTORS-1:0] led_mask;
    logic                 done_pulse;
    logic                 dwell_en;
    logic                 dwell_tick;

    function automatic logic [GROUP_W-1:0] next_group(input logic [GROUP_W-1:0] g);
        return (g == LAST_GROUP) ? '0 : g + GROUP_W'(1);
    endfunction

    // The timer only counts while running; any other state or an abort holds it at zero,
    // so every entry into RUN starts a fresh dwell step.
    assign dwell_en = (state == ST_RUN) && !bus.abort;

    sector_sequencer_dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_dwell_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!dwell_en),
        .enable (dwell_en),
        .tick   (dwell_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            sector_idx   <= '0;
            sector_group <= '0;
            led_mask     <= '0;
            done_pulse   <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (bus.abort) begin
                state      <= ST_IDLE;
                sector_idx <= '0;
                led_mask   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start_pulse) begin
                            state      <= ST_RUN;
                            sector_idx <= '0;
                            led_mask   <= FIRST_MASK;
                        end
                    end
                    ST_RUN: begin
                        if (dwell_tick) begin
                            if (sector_idx == LAST_SECTOR) begin
                                state      <= ST_DONE;
                                done_pulse <= 1'b1;
                            end else begin
                                sector_idx <= sector_idx + SECTOR_W'(1);
                                led_mask   <= led_mask | (FIRST_MASK << (sector_idx + SECTOR_W'(1)));
                            end
                        end
                    end
                    ST_DONE: begin
                        // A group change and a start in the same cycle both take effect.
                        if (bus.change_sector_group) begin
                            sector_group <= next_group(sector_group);
                        end
                        if (bus.start_pulse) begin
                            state      <= ST_RUN;
                            sector_idx <= '0;
                            led_mask   <= FIRST_MASK;
                        end else if (bus.change_sector_group) begin
                            state      <= ST_IDLE;
                            sector_idx <= '0;
                            led_mask   <= '0;
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        sector_idx <= '0;
                        led_mask   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.main_state   = state;
    assign bus.sector_group = sector_group;
    assign bus.sector_idx   = sector_idx;
    assign bus.led_mask     = led_mask;
    assign bus.done_pulse   = done_pulse;
    assign bus.busy         = (state == ST_RUN);

endmodule

// File: tb/tb_sector_sequencer.sv
// Directed bench for sector_sequencer with a small geometry (4-cycle dwell,
// 4 sectors, 3 groups); expected outputs are queued per cycle and checked after each edge.
module tb_sector_sequencer;
    import sector_sequencer_pkg::*;

    localparam int DW = 4;
    localparam int NS = 4;
    localparam int NG = 3;
    localparam int SW = 2;
    localparam int GW = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;

    sector_sequencer_if #(.N_SECTORS(NS), .SECTOR_W(SW), .GROUP_W(GW)) bus ();

    sector_sequencer #(
        .DWELL_CYCLES(DW),
        .N_SECTORS   (NS),
        .N_GROUPS    (NG),
        .SECTOR_W    (SW),
        .GROUP_W     (GW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        state_t        st;
        logic [GW-1:0] grp;
        logic [SW-1:0] idx;
        logic [NS-1:0] mask;
        logic          dp;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int busy_cycles = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".state"}, 8'(bus.main_state),   8'(e.st));
            chk({e.tag, ".group"}, 8'(bus.sector_group), 8'(e.grp));
            chk({e.tag, ".idx"},   8'(bus.sector_idx),   8'(e.idx));
            chk({e.tag, ".mask"},  8'(bus.led_mask),     8'(e.mask));
            chk({e.tag, ".done"},  8'(bus.done_pulse),   8'(e.dp));
            chk({e.tag, ".busy"},  8'(bus.busy),         8'(e.st == ST_RUN));
        end
    endtask

    // Drive one cycle of inputs, queue what must be visible after the edge, then check it.
    task automatic tick(input logic s, input logic c, input logic a, input state_t st,
                        input logic [GW-1:0] grp, input logic [SW-1:0] idx,
                        input logic [NS-1:0] mask, input logic dp, input string tag);
        exp_t e;
        e.tag = tag; e.st = st; e.grp = grp; e.idx = idx; e.mask = mask; e.dp = dp;
        sb.push_back(e);
        bus.start_pulse         = s;
        bus.change_sector_group = c;
        bus.abort               = a;
        @(posedge clk);
        #1;
        bus.start_pulse         = 1'b0;
        bus.change_sector_group = 1'b0;
        bus.abort               = 1'b0;
        if (bus.busy === 1'b1) busy_cycles++;
        compare_out();
    endtask

    // Start press followed by up to last_k RUN cycles; last_k>=16 also covers DONE entry.
    task automatic do_run(input logic [GW-1:0] grp, input logic with_chg, input int last_k,
                          input logic noise, input string tag);
        logic [NS-1:0] m;
        tick(1'b1, with_chg, 1'b0, ST_RUN, grp, '0, NS'(1), 1'b0, {tag, ".k0"});
        for (int k = 1; k <= last_k && k <= 15; k++) begin
            m = NS'((1 << (k / DW + 1)) - 1);
            tick(noise && (k == 9), noise && (k == 5), 1'b0, ST_RUN, grp, SW'(k / DW), m, 1'b0,
                 $sformatf("%s.k%0d", tag, k));
        end
        if (last_k >= 16) begin
            tick(1'b0, 1'b0, 1'b0, ST_DONE, grp, SW'(NS - 1), '1, 1'b1, {tag, ".done"});
            tick(1'b0, 1'b0, 1'b0, ST_DONE, grp, SW'(NS - 1), '1, 1'b0, {tag, ".hold"});
        end
    endtask

    initial begin
        bus.start_pulse         = 1'b0;
        bus.change_sector_group = 1'b0;
        bus.abort               = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.state", 8'(bus.main_state), 8'(ST_IDLE));
        chk("rst.mask",  8'(bus.led_mask),   8'h00);
        chk("rst.group", 8'(bus.sector_group), 8'h00);
        chk("rst.done",  8'(bus.done_pulse), 8'h00);
        reset = 1'b1;

        // Group change in IDLE is ignored.
        tick(1'b0, 1'b1, 1'b0, ST_IDLE, 2'd0, '0, '0, 1'b0, "idle_chg");
        tick(1'b0, 1'b0, 1'b0, ST_IDLE, 2'd0, '0, '0, 1'b0, "idle");

        // Full fill with stray change/start presses during RUN.
        busy_cycles = 0;
        do_run(2'd0, 1'b0, 16, 1'b1, "run0");
        chk("busy_cycles", 8'(busy_cycles), 8'd16);

        // Three group changes from DONE, wrapping 1, 2, 0.
        for (int g = 1; g <= 3; g++) begin
            tick(1'b0, 1'b1, 1'b0, ST_IDLE, GW'(g % NG), '0, '0, 1'b0, $sformatf("chg%0d", g));
            tick(1'b0, 1'b0, 1'b0, ST_IDLE, GW'(g % NG), '0, '0, 1'b0, $sformatf("chg%0d.idle", g));
            do_run(GW'(g % NG), 1'b0, 16, 1'b0, $sformatf("grp%0d", g));
        end

        // Start alone in DONE restarts with the same group.
        do_run(2'd0, 1'b0, 16, 1'b0, "restart");

        // Abort at sector 1 of RUN.
        do_run(2'd0, 1'b0, 5, 1'b0, "abort_run");
        tick(1'b0, 1'b0, 1'b1, ST_IDLE, 2'd0, '0, '0, 1'b0, "abort_s1");
        tick(1'b0, 1'b0, 1'b0, ST_IDLE, 2'd0, '0, '0, 1'b0, "abort_s1.idle");

        // Abort wins over a group change in DONE.
        do_run(2'd0, 1'b0, 16, 1'b0, "pre_abort");
        tick(1'b0, 1'b1, 1'b1, ST_IDLE, 2'd0, '0, '0, 1'b0, "abort_chg");

        // Group change together with start in DONE.
        do_run(2'd0, 1'b0, 16, 1'b0, "pre_combo");
        do_run(2'd1, 1'b1, 9, 1'b0, "combo");

        // Asynchronous reset while at sector 2, checked before the next edge.
        #2;
        reset = 1'b0;
        #1;
        chk("arst.state", 8'(bus.main_state),   8'(ST_IDLE));
        chk("arst.mask",  8'(bus.led_mask),     8'h00);
        chk("arst.group", 8'(bus.sector_group), 8'h00);
        chk("arst.idx",   8'(bus.sector_idx),   8'h00);
        chk("arst.busy",  8'(bus.busy),         8'h00);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0, ST_IDLE, 2'd0, '0, '0, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sector_sequencer.md
Name: sector_sequencer

Overview:
Main control FSM for the LED sector display. It produces the 2-bit main_state consumed by the button handler. On a start press it fills the sectors one at a time, each lit for a fixed dwell time, then holds in DONE. In DONE, the debounced change_sector_group pulse advances the active sector group (wrapping) and returns the block to IDLE.

Parameters:
DWELL_CYCLES, 25000000, clock cycles each sector step lasts (1 s at 25 MHz); legal range >= 1
N_SECTORS, 8, number of sectors per group; legal range >= 2
N_GROUPS, 4, number of sector groups; need not be a power of 2
SECTOR_W, 3, width of sector_idx; must be >= clog2(N_SECTORS)
GROUP_W, 2, width of sector_group; must be >= clog2(N_GROUPS)

Ports:
clk  input  1  system clock, 25 MHz
reset  input  1  asynchronous, active-low reset
start_pulse  input  1  one-cycle debounced start press
change_sector_group  input  1  one-cycle pulse from button handler; acted on only in DONE
abort  input  1  synchronous abort; level-sensitive, sampled each cycle
main_state  output  2  IDLE=2'b00, RUN=2'b01, DONE=2'b10
sector_group  output  GROUP_W  active group index
sector_idx  output  SECTOR_W  sector currently being filled
led_mask  output  N_SECTORS  cumulative lit sectors, bit i = sector i
busy  output  1  high when main_state==RUN (combinational decode of the state register)
done_pulse  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (reset low, asynchronous): main_state=IDLE, sector_group=0, sector_idx=0, led_mask=0, dwell_cnt=0, done_pulse=0. Outputs take these values immediately, including mid-RUN. Release is synchronous to clk.
- All registered outputs update on the rising clk edge. Decisions below use inputs sampled on that edge.
- Priority each cycle: abort > change_sector_group > start_pulse.
- IDLE:
  - start_pulse=1 -> next cycle: RUN, sector_idx=0, dwell_cnt=0, led_mask=1 (bit 0 set).
  - change_sector_group is ignored.
- RUN:
  - dwell_cnt increments every cycle.
  - At dwell_cnt==DWELL_CYCLES-1 with sector_idx<N_SECTORS-1: sector_idx+1, led_mask |= 1<<(sector_idx+1), dwell_cnt=0.
  - At dwell_cnt==DWELL_CYCLES-1 with sector_idx==N_SECTORS-1: enter DONE, done_pulse=1 for exactly one cycle, led_mask stays all-ones, dwell_cnt=0.
  - RUN lasts exactly N_SECTORS*DWELL_CYCLES cycles.
  - start_pulse and change_sector_group are ignored in RUN.
- DONE:
  - change_sector_group=1 -> sector_group = (sector_group==N_GROUPS-1) ? 0 : sector_group+1; led_mask=0; sector_idx=0; next state IDLE.
  - start_pulse=1 alone -> restart RUN with the same group, exactly as from IDLE.
  - change_sector_group and start_pulse in the same cycle -> advance the group AND enter RUN (led_mask=1).
- abort=1 in any state -> next cycle IDLE, led_mask=0, sector_idx=0, dwell_cnt=0, done_pulse=0. sector_group is unchanged.
- Illegal state 2'b11 -> IDLE on the next edge with all registers cleared except sector_group.
- dwell_cnt width = max(1, clog2(DWELL_CYCLES)). With DWELL_CYCLES=1 the block advances one sector per cycle.
- sector_group arithmetic is modulo N_GROUPS. The counter never reaches N_GROUPS.

Decomposition:
- Shared header/package led_defs: state encodings IDLE/RUN/DONE (DONE must equal the value the button handler compares against) and default DWELL_CYCLES / N_SECTORS / N_GROUPS.
- One natural sub-module: dwell_timer (clear, enable, terminal-count tick output; parameter DWELL_CYCLES).
- FSM, sector/group counters and mask logic stay in sector_sequencer.

Test Plan:
(bench params DWELL_CYCLES=4, N_SECTORS=4, N_GROUPS=3)
1. Reset low mid-RUN at sector 2 -> outputs go 0/IDLE without a clock edge. After release, main_state=00 and led_mask=0000.
2. start_pulse in IDLE at cycle T -> main_state=01 at T+1. led_mask steps 0001, 0011, 0111, 1111 every 4 cycles. main_state=10 and done_pulse=1 at T+17 only. busy is high for exactly 16 cycles.
3. In DONE, pulse change_sector_group three times, each followed by start and completion -> sector_group sequence 1, 2, 0 (wrap). Each pulse returns main_state to 00 with led_mask=0.
4. change_sector_group during IDLE and RUN, and start_pulse during RUN -> no change to state, group or mask timing.
5. abort at sector 1 of RUN -> IDLE next cycle, led_mask=0, group unchanged. abort together with change_sector_group in DONE -> IDLE, group unchanged.
6. change_sector_group and start_pulse in the same DONE cycle -> group+1, main_state=01, led_mask=0001 next cycle.
